// File: rtl/warp_issue_scheduler.sv
// warp_issue_scheduler
//   Per-SM warp scheduler. Tracks each warp's lifecycle (IDLE/READY/WAIT) and PC,
//   and fills a single issue slot with the next eligible warp in round-robin order
//   starting after the last accepted warp. The slot is offered to the front end
//   over a valid/ready handshake.
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   launch_valid/id/pc             start an IDLE warp at a PC
//   stall_valid/id/cycles          park a warp in WAIT (0 = until woken, N = self-wake after N)
//   wake_valid/id                  force a WAIT warp back to READY
//   exit_valid/id                  retire a warp to IDLE
//   issue_valid/ready/warp_id/pc   issue slot handshake to fetch/decode
//   active_mask                    bit w set when warp w is not IDLE
//   all_done                       no active warp and the slot is empty
module warp_issue_scheduler #(
   parameter  int unsigned NUM_WARPS = 4,
   parameter  int unsigned PC_W      = 32,
   parameter  int unsigned WAIT_W    = 4,
   localparam int unsigned WID_W     = $clog2(NUM_WARPS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 launch_valid,
   input  logic [WID_W-1:0]     launch_id,
   input  logic [PC_W-1:0]      launch_pc,
   input  logic                 stall_valid,
   input  logic [WID_W-1:0]     stall_id,
   input  logic [WAIT_W-1:0]    stall_cycles,
   input  logic                 wake_valid,
   input  logic [WID_W-1:0]     wake_id,
   input  logic                 exit_valid,
   input  logic [WID_W-1:0]     exit_id,
   output logic                 issue_valid,
   input  logic                 issue_ready,
   output logic [WID_W-1:0]     issue_warp_id,
   output logic [PC_W-1:0]      issue_pc,
   output logic [NUM_WARPS-1:0] active_mask,
   output logic                 all_done
);

   typedef enum logic [1:0] {StIdle, StReady, StWait} warp_state_e;

   warp_state_e       state_q [NUM_WARPS];
   warp_state_e       state_d [NUM_WARPS];
   logic [PC_W-1:0]   pc_q    [NUM_WARPS];
   logic [PC_W-1:0]   pc_d    [NUM_WARPS];
   logic [WAIT_W-1:0] cnt_q   [NUM_WARPS];
   logic [WAIT_W-1:0] cnt_d   [NUM_WARPS];

   logic              slot_valid_q, slot_valid_d;
   logic [WID_W-1:0]  slot_id_q,    slot_id_d;
   logic [PC_W-1:0]   slot_pc_q,    slot_pc_d;
   logic [WID_W-1:0]  ptr_q,        ptr_d;

   logic              accept;
   logic [WID_W-1:0]  search_base;
   logic [WID_W-1:0]  cand;
   logic [WID_W-1:0]  sel_id;
   logic              sel_found;

   assign accept = slot_valid_q & issue_ready;

   // Per-warp lifecycle and PC next state
   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         logic ev_exit, ev_stall, ev_wake, ev_launch;
         ev_exit   = exit_valid   && (exit_id   == WID_W'(w));
         ev_stall  = stall_valid  && (stall_id  == WID_W'(w));
         ev_wake   = wake_valid   && (wake_id   == WID_W'(w));
         ev_launch = launch_valid && (launch_id == WID_W'(w));

         state_d[w] = state_q[w];
         pc_d[w]    = pc_q[w];
         cnt_d[w]   = cnt_q[w];

         // Self-wake countdown; any event below overrides it
         if (state_q[w] == StWait && cnt_q[w] != '0) begin
            cnt_d[w] = cnt_q[w] - 1'b1;
            if (cnt_q[w] == WAIT_W'(1)) begin
               state_d[w] = StReady;
            end
         end

         if (accept && slot_id_q == WID_W'(w) && !ev_exit) begin
            pc_d[w] = slot_pc_q + PC_W'(4);
         end

         // Strict per-warp priority: the highest asserted event masks the rest
         if (ev_exit) begin
            state_d[w] = StIdle;
            cnt_d[w]   = '0;
         end else if (ev_stall) begin
            if (state_q[w] != StIdle) begin
               state_d[w] = StWait;
               cnt_d[w]   = stall_cycles;
            end
         end else if (ev_wake) begin
            if (state_q[w] == StWait) begin
               state_d[w] = StReady;
               cnt_d[w]   = '0;
            end
         end else if (ev_launch) begin
            if (state_q[w] == StIdle) begin
               state_d[w] = StReady;
               pc_d[w]    = launch_pc;
               cnt_d[w]   = '0;
            end
         end
      end
   end

   // Round-robin pick. On an accepting edge the accepted warp is the effective
   // pointer, so back-to-back issue continues from it rather than the stale ptr.
   always_comb begin
      search_base = accept ? slot_id_q : ptr_q;
      sel_found   = 1'b0;
      sel_id      = '0;
      cand        = '0;
      for (int i = 1; i <= NUM_WARPS; i++) begin
         cand = WID_W'((int'(search_base) + i) % NUM_WARPS);
         if (!sel_found && state_q[cand] == StReady &&
             !(slot_valid_q && slot_id_q == cand)) begin
            sel_found = 1'b1;
            sel_id    = cand;
         end
      end
   end

   // Issue slot: reload only when empty or draining; otherwise hold stable
   always_comb begin
      slot_valid_d = slot_valid_q;
      slot_id_d    = slot_id_q;
      slot_pc_d    = slot_pc_q;
      ptr_d        = accept ? slot_id_q : ptr_q;
      if (!slot_valid_q || accept) begin
         slot_valid_d = sel_found;
         if (sel_found) begin
            slot_id_d = sel_id;
            slot_pc_d = pc_q[sel_id];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            state_q[w] <= StIdle;
            pc_q[w]    <= '0;
            cnt_q[w]   <= '0;
         end
         slot_valid_q <= 1'b0;
         slot_id_q    <= '0;
         slot_pc_q    <= '0;
         ptr_q        <= '0;
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            state_q[w] <= state_d[w];
            pc_q[w]    <= pc_d[w];
            cnt_q[w]   <= cnt_d[w];
         end
         slot_valid_q <= slot_valid_d;
         slot_id_q    <= slot_id_d;
         slot_pc_q    <= slot_pc_d;
         ptr_q        <= ptr_d;
      end
   end

   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         active_mask[w] = (state_q[w] != StIdle);
      end
   end

   assign issue_valid   = slot_valid_q;
   assign issue_warp_id = slot_id_q;
   assign issue_pc      = slot_pc_q;
   assign all_done      = (active_mask == '0) && !slot_valid_q;

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// tb_warp_issue_scheduler
//   Directed scenarios for warp_issue_scheduler. Expected issues are pushed to a
//   scoreboard queue when stimulus is driven and popped on each observed handshake.
module tb_warp_issue_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        launch_valid = 1'b0;
   logic [1:0]  launch_id = '0;
   logic [31:0] launch_pc = '0;
   logic        stall_valid = 1'b0;
   logic [1:0]  stall_id = '0;
   logic [3:0]  stall_cycles = '0;
   logic        wake_valid = 1'b0;
   logic [1:0]  wake_id = '0;
   logic        exit_valid = 1'b0;
   logic [1:0]  exit_id = '0;
   logic        issue_valid;
   logic        issue_ready = 1'b0;
   logic [1:0]  issue_warp_id;
   logic [31:0] issue_pc;
   logic [3:0]  active_mask;
   logic        all_done;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] pc;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   warp_issue_scheduler dut (
      .clk          (clk),
      .reset        (reset),
      .launch_valid (launch_valid),
      .launch_id    (launch_id),
      .launch_pc    (launch_pc),
      .stall_valid  (stall_valid),
      .stall_id     (stall_id),
      .stall_cycles (stall_cycles),
      .wake_valid   (wake_valid),
      .wake_id      (wake_id),
      .exit_valid   (exit_valid),
      .exit_id      (exit_id),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .issue_warp_id(issue_warp_id),
      .issue_pc     (issue_pc),
      .active_mask  (active_mask),
      .all_done     (all_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      launch_valid = 1'b0;
      stall_valid  = 1'b0;
      wake_valid   = 1'b0;
      exit_valid   = 1'b0;
      issue_ready  = 1'b0;
      sb_q.delete();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic launch(input logic [1:0] id, input logic [31:0] pc);
      launch_valid = 1'b1;
      launch_id    = id;
      launch_pc    = pc;
      step();
      launch_valid = 1'b0;
   endtask

   task automatic exit_warp(input logic [1:0] id);
      exit_valid = 1'b1;
      exit_id    = id;
      step();
      exit_valid = 1'b0;
   endtask

   task automatic push(input logic [1:0] id, input logic [31:0] pc);
      exp_t e;
      e.id = id;
      e.pc = pc;
      sb_q.push_back(e);
   endtask

   task automatic drain(input string tag, input int limit);
      for (int i = 0; i < limit && sb_q.size() != 0; i++) step();
      check_eq(tag, 64'(sb_q.size()), 64'd0);
   endtask

   // Handshake monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (!reset && issue_valid && issue_ready) begin
         if (sb_q.size() == 0) begin
            check_eq("issue_expected", 64'(sb_q.size()), 64'd1);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("issue_id", 64'(issue_warp_id), 64'(e.id));
            check_eq("issue_pc", 64'(issue_pc), 64'(e.pc));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // 1: reset state, single warp issues with PC +4 per issue
      do_reset();
      reset = 1'b1;
      #1;
      check_eq("rst_valid", 64'(issue_valid), 64'd0);
      check_eq("rst_id", 64'(issue_warp_id), 64'd0);
      check_eq("rst_pc", 64'(issue_pc), 64'd0);
      check_eq("rst_mask", 64'(active_mask), 64'd0);
      check_eq("rst_done", 64'(all_done), 64'd1);
      reset = 1'b0;
      step();
      issue_ready = 1'b1;
      push(2'd0, 32'h100);
      push(2'd0, 32'h104);
      push(2'd0, 32'h108);
      launch(2'd0, 32'h100);
      check_eq("t1_lat_k", 64'(issue_valid), 64'd0);
      check_eq("t1_mask", 64'(active_mask), 64'd1);
      step();
      check_eq("t1_lat_k1", 64'(issue_valid), 64'd1);
      drain("t1_drain", 30);
      issue_ready = 1'b0;

      // 2: four warps, round-robin order after the last accepted warp
      do_reset();
      launch(2'd1, 32'h1000);
      launch(2'd2, 32'h2000);
      launch(2'd3, 32'h3000);
      launch(2'd0, 32'h0);
      push(2'd1, 32'h1000);
      push(2'd2, 32'h2000);
      push(2'd3, 32'h3000);
      push(2'd0, 32'h0);
      push(2'd1, 32'h1004);
      push(2'd2, 32'h2004);
      push(2'd3, 32'h3004);
      push(2'd0, 32'h4);
      issue_ready = 1'b1;
      drain("t2_drain", 40);
      issue_ready = 1'b0;

      // 3: slot held stable under backpressure, stalled slot warp still accepted once
      do_reset();
      launch(2'd2, 32'h2000);
      launch(2'd3, 32'h3000);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            stall_valid  = 1'b1;
            stall_id     = 2'd2;
            stall_cycles = 4'd0;
         end
         step();
         stall_valid = 1'b0;
         check_eq("t3_hold_valid", 64'(issue_valid), 64'd1);
         check_eq("t3_hold_id", 64'(issue_warp_id), 64'd2);
         check_eq("t3_hold_pc", 64'(issue_pc), 64'h2000);
      end
      push(2'd2, 32'h2000);
      push(2'd3, 32'h3000);
      push(2'd3, 32'h3004);
      push(2'd3, 32'h3008);
      issue_ready = 1'b1;
      drain("t3_drain_a", 40);
      issue_ready = 1'b0;
      push(2'd3, 32'h300c);
      push(2'd2, 32'h2004);
      wake_valid = 1'b1;
      wake_id    = 2'd2;
      step();
      wake_valid  = 1'b0;
      issue_ready = 1'b1;
      drain("t3_drain_b", 40);
      issue_ready = 1'b0;

      // 4: timed stall of 3 cycles, then indefinite stall until wake
      do_reset();
      launch(2'd1, 32'h1000);
      step();
      push(2'd1, 32'h1000);
      push(2'd1, 32'h1004);
      issue_ready  = 1'b1;
      stall_valid  = 1'b1;
      stall_id     = 2'd1;
      stall_cycles = 4'd3;
      step();
      stall_valid = 1'b0;
      check_eq("t4_wait0", 64'(issue_valid), 64'd0);
      for (int i = 1; i <= 3; i++) begin
         step();
         check_eq("t4_wait", 64'(issue_valid), 64'd0);
      end
      step();
      check_eq("t4_back_valid", 64'(issue_valid), 64'd1);
      check_eq("t4_back_pc", 64'(issue_pc), 64'h1004);
      stall_valid  = 1'b1;
      stall_cycles = 4'd0;
      step();
      stall_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check_eq("t4_parked", 64'(issue_valid), 64'd0);
         step();
      end
      issue_ready = 1'b0;
      wake_valid  = 1'b1;
      wake_id     = 2'd1;
      step();
      wake_valid = 1'b0;
      check_eq("t4_wake_k", 64'(issue_valid), 64'd0);
      step();
      check_eq("t4_wake_valid", 64'(issue_valid), 64'd1);
      check_eq("t4_wake_pc", 64'(issue_pc), 64'h1008);
      check_eq("t4_sb_empty", 64'(sb_q.size()), 64'd0);

      // 5: exit beats stall and launch on the same warp; all_done after drain
      do_reset();
      launch(2'd0, 32'h0);
      launch(2'd1, 32'h1000);
      launch(2'd2, 32'h2000);
      launch(2'd3, 32'h3000);
      check_eq("t5_mask_all", 64'(active_mask), 64'hf);
      exit_valid   = 1'b1;
      exit_id      = 2'd3;
      stall_valid  = 1'b1;
      stall_id     = 2'd3;
      stall_cycles = 4'd2;
      launch_valid = 1'b1;
      launch_id    = 2'd3;
      launch_pc    = 32'h9990;
      step();
      exit_valid   = 1'b0;
      stall_valid  = 1'b0;
      launch_valid = 1'b0;
      check_eq("t5_mask_exit3", 64'(active_mask), 64'h7);
      check_eq("t5_done_busy", 64'(all_done), 64'd0);
      exit_warp(2'd0);
      exit_warp(2'd1);
      exit_warp(2'd2);
      check_eq("t5_mask_none", 64'(active_mask), 64'd0);
      check_eq("t5_slot_kept", 64'(issue_valid), 64'd1);
      check_eq("t5_done_slot", 64'(all_done), 64'd0);
      push(2'd0, 32'h0);
      issue_ready = 1'b1;
      drain("t5_drain", 20);
      issue_ready = 1'b0;
      check_eq("t5_done", 64'(all_done), 64'd1);
      check_eq("t5_empty", 64'(issue_valid), 64'd0);

      // 6: asynchronous reset drops an in-flight slot without a clock edge
      do_reset();
      launch(2'd0, 32'h40);
      step();
      check_eq("t6_inflight", 64'(issue_valid), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("t6_valid", 64'(issue_valid), 64'd0);
      check_eq("t6_id", 64'(issue_warp_id), 64'd0);
      check_eq("t6_pc", 64'(issue_pc), 64'd0);
      check_eq("t6_mask", 64'(active_mask), 64'd0);
      check_eq("t6_done", 64'(all_done), 64'd1);
      step();
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
